ripple_count_capture: RTL and testbench



---
 rtl/ripple_count_capture.sv | 69 ++++++
 tb/tb_ripple_count_capture.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ripple_count_capture.sv
// ripple_count_capture: synchronizes and stability-filters a ripple count, accumulates deltas into a handshaked total.
// Define RIPPLE_CAPTURE_SATURATE_EN to clamp the total at all-ones instead of wrapping.
module ripple_count_capture #(
  parameter int CNT_W = 4,
  parameter int ACC_W = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             overflow
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);
  typedef enum logic {TRACK, STABLE} state_t;
  state_t r_state, w_state_n;
  logic [CNT_W-1:0] r_s1, r_s2, r_last, w_delta;
  logic [SW-1:0] r_stab, w_stab_n;
  logic [ACC_W-1:0] w_base, w_acc_total;
  logic [ACC_W:0] w_sum;
  logic w_same, w_accept;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= cnt_in;
      r_s2 <= r_s1;
    end
  // s1 is the value s2 loads next, so equality means s2 holds across this edge
  assign w_same = r_s1 == r_s2;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= TRACK;
      r_stab <= '0;
    end else begin
      r_state <= w_state_n;
      r_stab <= w_stab_n;
    end
  always_comb begin
    w_state_n = !w_same ? TRACK : (r_state == TRACK && r_stab == LAST) ? STABLE : r_state;
    w_stab_n = (w_same && r_state == TRACK && r_stab != LAST) ? r_stab + 1'b1 : '0;
  end
  always_comb w_accept = r_state == TRACK && w_same && r_stab == LAST && r_s2 != r_last;
  assign w_delta = r_s2 - r_last;
  assign w_base = clr ? '0 : out_total;
  assign w_sum = {1'b0, w_base} + {{(ACC_W - CNT_W + 1){1'b0}}, w_delta};
`ifdef RIPPLE_CAPTURE_SATURATE_EN
  assign w_acc_total = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_total = w_sum[ACC_W-1:0];
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_last <= '0;
      out_total <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_last <= w_accept ? r_s2 : r_last;
      out_total <= w_accept ? w_acc_total : w_base;
      out_valid <= w_accept | (out_valid & ~out_ready & ~clr);
      overflow <= (overflow & ~clr) | (w_accept & w_sum[ACC_W]);
    end
endmodule

// File: tb/tb_ripple_count_capture.sv
// tb_ripple_count_capture: directed plus random stimulus against a run-length reference model.
module tb_ripple_count_capture;
  localparam int S = 2;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, out_ready = 1'b0;
  logic [3:0] cnt_in = '0;
  logic out_valid, overflow;
  logic [15:0] out_total;
  int n_cmp = 0, n_bad = 0;
  int m_s1, m_s2, m_last, run, m_total, v;
  bit m_valid, m_ovf;
  always #5 clk = ~clk;
  ripple_count_capture dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_total(out_total), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_s1 = 0; m_s2 = 0; m_last = 0; run = 1; m_total = 0; m_valid = 0; m_ovf = 0;
  endtask
  // s2 must hold S+1 edges; accept when the run first reaches that length with a new value
  task automatic model_edge();
    int s2n, delta, sum;
    bit acc, hs;
    s2n = m_s1;
    m_s1 = int'(cnt_in);
    run = (s2n == m_s2) ? run + 1 : 1;
    m_s2 = s2n;
    acc = run == S + 1 && m_s2 != m_last;
    hs = m_valid && out_ready;
    if (acc) begin
      delta = (m_s2 - m_last + 16) % 16;
      m_last = m_s2;
      sum = (clr ? 0 : m_total) + delta;
      if (clr) m_ovf = 0;
      if (sum > 65535) begin
        m_ovf = 1;
`ifdef RIPPLE_CAPTURE_SATURATE_EN
        m_total = 65535;
`else
        m_total = sum - 65536;
`endif
      end else m_total = sum;
      m_valid = 1;
    end else if (clr) begin
      m_total = 0; m_ovf = 0; m_valid = 0;
    end else if (hs) m_valid = 0;
  endtask
  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk("valid", out_valid, m_valid);
    chk("total", out_total, m_total);
    chk("ovf", overflow, m_ovf);
  endtask
  task automatic hold(input int val, input int n);
    cnt_in = 4'(val);
    repeat (n) step();
  endtask
  initial begin
    m_reset();
    #1;
    chk("rst valid", out_valid, 0);
    chk("rst total", out_total, 0);
    chk("rst ovf", overflow, 0);
    @(negedge clk) reset = 1'b0;
    hold(0, 3);
    cnt_in = 4'd3;
    repeat (3) step();
    chk("lat early", out_valid, 0);
    step();
    chk("lat valid", out_valid, 1);
    chk("lat total", out_total, 3);
    out_ready = 1'b1;
    step();
    chk("hs drop", out_valid, 0);
    hold(15, 4);
    hold(0, 4);
    chk("wrap", out_total, 16);
    hold(6, 4);
    hold(7, 1);
    hold(6, 5);
    chk("glitch", out_total, 22);
    hold(8, 4);
    chk("after glitch", out_total, 24);
    out_ready = 1'b0;
    hold(10, 4);
    hold(13, 4);
    chk("coalesce valid", out_valid, 1);
    chk("coalesce total", out_total, 29);
    cnt_in = 4'd14;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    chk("hs+acc valid", out_valid, 1);
    chk("hs+acc total", out_total, 30);
    step();
    chk("hs after", out_valid, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr total", out_total, 0);
    v = 14;
    for (int i = 0; i < 4368; i++) begin
      v = (v + 15) % 16;
      hold(v, 4);
    end
    v = (v + 14) % 16;
    hold(v, 4);
    chk("near top", out_total, 16'hFFFE);
    chk("near top ovf", overflow, 0);
    v = (v + 3) % 16;
    hold(v, 4);
`ifdef RIPPLE_CAPTURE_SATURATE_EN
    chk("sat total", out_total, 16'hFFFF);
`else
    chk("wrap total", out_total, 16'h0001);
`endif
    chk("ovf set", overflow, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr ovf", overflow, 0);
    chk("clr total2", out_total, 0);
    out_ready = 1'b0;
    hold((v + 5) % 16, 4);
    chk("pre-rst valid", out_valid, 1);
    reset = 1'b1;
    #1;
    m_reset();
    chk("mid rst valid", out_valid, 0);
    chk("mid rst total", out_total, 0);
    chk("mid rst ovf", overflow, 0);
    cnt_in = 4'd2;
    @(negedge clk) reset = 1'b0;
    repeat (4) step();
    chk("post rst total", out_total, 2);
    chk("post rst valid", out_valid, 1);
    for (int i = 0; i < 2000; i++) begin
      cnt_in = 4'($urandom);
      repeat ($urandom_range(1, 6)) begin
        out_ready = 1'($urandom);
        clr = ($urandom % 16) == 0;
        step();
      end
    end
    clr = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
